// File: rtl/ia_packet_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ia_packet_rx_if
// Brief    : Byte-in / register-write-out bundle for the packet assembler.
// Revision : 1.0 - initial release
// ============================================================================
interface ia_packet_rx_if #(
   parameter int IDX_W = 6
);
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic [7:0]       read_data;
   logic [IDX_W-1:0] idx;
   logic             update_reg;
   logic             pc_ready;
   logic             frame_err;
   logic             busy;

   modport master (
      output byte_valid, byte_data,
      input  read_data, idx, update_reg, pc_ready, frame_err, busy
   );

   modport slave (
      input  byte_valid, byte_data,
      output read_data, idx, update_reg, pc_ready, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/ia_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : ia_packet_rx
// Brief    : Sync-framed packet assembler feeding the register file.
//            Optional trailing XOR checksum enabled by macro IA_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ia_packet_rx #(
   parameter int         NUM_BYTES      = 55,
   parameter int         IDX_W          = 6,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter int         TO_W           = 16
) (
   input  wire logic     clk,
   input  wire logic     reset_n,
   ia_packet_rx_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
`ifdef IA_CHECKSUM_EN
   localparam logic [1:0] S_CHK  = 2'd3;
`endif

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit               c_TO_EN    = (TIMEOUT_CYCLES > 0);

   logic [1:0]       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_count, w_count_nxt;
   logic [TO_W-1:0]  r_timer, w_timer_nxt;
   logic [7:0]       r_read_data, w_read_data_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic             r_update_reg, w_update_nxt;
   logic             r_pc_ready, w_pc_nxt;
   logic             r_frame_err, w_fe_nxt;
   logic             w_busy;
   logic             w_timeout;
   logic             w_sync;
`ifdef IA_CHECKSUM_EN
   logic [7:0]       r_xsum, w_xsum_nxt;
`endif

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_timer      <= '0;
         r_read_data  <= '0;
         r_idx        <= '0;
         r_update_reg <= 1'b0;
         r_pc_ready   <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef IA_CHECKSUM_EN
         r_xsum       <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_timer      <= w_timer_nxt;
         r_read_data  <= w_read_data_nxt;
         r_idx        <= w_idx_nxt;
         r_update_reg <= w_update_nxt;
         r_pc_ready   <= w_pc_nxt;
         r_frame_err  <= w_fe_nxt;
`ifdef IA_CHECKSUM_EN
         r_xsum       <= w_xsum_nxt;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_timer_nxt = r_timer;
      w_timeout   = c_TO_EN && (r_timer == c_TO_LAST);
      w_sync      = bus.byte_valid && (bus.byte_data == SYNC_BYTE);
`ifdef IA_CHECKSUM_EN
      w_xsum_nxt  = r_xsum;
`endif
      case (r_state)
         S_IDLE, S_DONE: begin
            // DONE lasts one cycle and evaluates incoming bytes like IDLE
            if (w_sync) begin
               w_state_nxt = S_RECV;
               w_count_nxt = '0;
               w_timer_nxt = '0;
`ifdef IA_CHECKSUM_EN
               w_xsum_nxt  = '0;
`endif
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RECV: begin
            if (bus.byte_valid) begin
               w_timer_nxt = '0;
`ifdef IA_CHECKSUM_EN
               w_xsum_nxt  = r_xsum ^ bus.byte_data;
`endif
               if (r_count == c_LAST_IDX) begin
`ifdef IA_CHECKSUM_EN
                  w_state_nxt = S_CHK;
`else
                  w_state_nxt = S_DONE;
`endif
               end else begin
                  w_count_nxt = r_count + IDX_W'(1);
               end
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end else if (c_TO_EN) begin
               w_timer_nxt = r_timer + TO_W'(1);
            end
         end
`ifdef IA_CHECKSUM_EN
         S_CHK: begin
            if (bus.byte_valid) begin
               w_timer_nxt = '0;
               w_state_nxt = (bus.byte_data == r_xsum) ? S_DONE : S_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end else if (c_TO_EN) begin
               w_timer_nxt = r_timer + TO_W'(1);
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      w_update_nxt    = (r_state == S_RECV) && bus.byte_valid;
      w_read_data_nxt = w_update_nxt ? bus.byte_data : r_read_data;
      w_idx_nxt       = w_update_nxt ? r_count : r_idx;
      w_pc_nxt        = (r_state == S_DONE);
      w_fe_nxt        = (r_state == S_RECV) && !bus.byte_valid && w_timeout;
      w_busy          = (r_state == S_RECV);
`ifdef IA_CHECKSUM_EN
      w_fe_nxt        = w_fe_nxt
                      || ((r_state == S_CHK) && !bus.byte_valid && w_timeout)
                      || ((r_state == S_CHK) && bus.byte_valid && (bus.byte_data != r_xsum));
      w_busy          = w_busy || (r_state == S_CHK);
`endif
   end

   assign bus.read_data  = r_read_data;
   assign bus.idx        = r_idx;
   assign bus.update_reg = r_update_reg;
   assign bus.pc_ready   = r_pc_ready;
   assign bus.frame_err  = r_frame_err;
   assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ia_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ia_packet_rx
// Brief    : Self-checking bench for ia_packet_rx (vector table, directed
//            sequences, randomized stream against a packet-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ia_packet_rx;
   localparam int         NB   = 4;
   localparam int         IW   = 3;
   localparam int         TO   = 20;
   localparam int         TOW  = 16;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef IA_CHECKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   logic clk;
   logic reset_n;
   ia_packet_rx_if #(.IDX_W(IW)) bus ();

   ia_packet_rx #(
      .NUM_BYTES(NB), .IDX_W(IW), .SYNC_BYTE(SYNC),
      .TIMEOUT_CYCLES(TO), .TO_W(TOW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_upd = 0, n_pc = 0, n_fe = 0;

   // Packet-level reference: in_pkt / bytes received / quiet cycles / running XOR
   bit         m_in_pkt, m_pc_pend;
   int         m_got, m_quiet, m_idx;
   logic [7:0] m_xs, m_data;
   bit         e_upd, e_pc, e_fe;

   typedef struct {
      bit bv; logic [7:0] bd;
      bit upd; logic [7:0] data; logic [IW-1:0] idx; bit pc; bit fe; bit busy;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_pkt = 0; m_pc_pend = 0; m_got = 0; m_quiet = 0;
      m_xs = 8'h00; m_data = 8'h00; m_idx = 0;
      e_upd = 0; e_pc = 0; e_fe = 0;
   endtask

   task automatic model_step(input bit bv, input logic [7:0] bd);
      e_upd = 0; e_pc = 0; e_fe = 0;
      if (m_pc_pend) begin e_pc = 1; m_pc_pend = 0; end
      if (!m_in_pkt) begin
         if (bv && bd == SYNC) begin m_in_pkt = 1; m_got = 0; m_quiet = 0; m_xs = 8'h00; end
      end else if (bv) begin
         m_quiet = 0;
         if (m_got < NB) begin
            e_upd = 1; m_data = bd; m_idx = m_got; m_xs ^= bd; m_got++;
            if (m_got == NB && !CKS) begin m_in_pkt = 0; m_pc_pend = 1; end
         end else begin
            m_in_pkt = 0;
            if (bd == m_xs) m_pc_pend = 1; else e_fe = 1;
         end
      end else if (m_quiet == TO - 1) begin
         m_in_pkt = 0; e_fe = 1;
      end else begin
         m_quiet++;
      end
   endtask

   task automatic cycle(input bit bv, input logic [7:0] bd);
      bus.byte_valid = bv;
      bus.byte_data  = bd;
      model_step(bv, bd);
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      n_upd += int'(bus.update_reg);
      n_pc  += int'(bus.pc_ready);
      n_fe  += int'(bus.frame_err);
      check("model update_reg", 32'(bus.update_reg), 32'(e_upd));
      check("model pc_ready",   32'(bus.pc_ready),   32'(e_pc));
      check("model frame_err",  32'(bus.frame_err),  32'(e_fe));
      check("model busy",       32'(bus.busy),       32'(m_in_pkt));
      check("model read_data",  32'(bus.read_data),  32'(m_data));
      check("model idx",        32'(bus.idx),        32'(m_idx));
   endtask

   task automatic v(input bit bv, input logic [7:0] bd, input bit upd, input logic [7:0] data,
                    input logic [IW-1:0] idx, input bit pc, input bit fe, input bit busy);
      vecs.push_back('{bv, bd, upd, data, idx, pc, fe, busy});
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int s_upd, s_pc, s_fe;
      bit rbv;
      logic [7:0] rbd;
      int gap;

      reset_n = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset read_data",  32'(bus.read_data),  32'h0);
      check("reset idx",        32'(bus.idx),        32'h0);
      check("reset update_reg", 32'(bus.update_reg), 32'h0);
      check("reset pc_ready",   32'(bus.pc_ready),   32'h0);
      check("reset frame_err",  32'(bus.frame_err),  32'h0);
      check("reset busy",       32'(bus.busy),       32'h0);
      reset_n = 1'b1;

`ifndef IA_CHECKSUM_EN
      // Basic packet, leading junk, back-to-back packets with sync in DONE
      v(1,8'hA5, 0,8'h00,0, 0,0,1);
      v(1,8'h11, 1,8'h11,0, 0,0,1);
      v(1,8'h22, 1,8'h22,1, 0,0,1);
      v(1,8'h33, 1,8'h33,2, 0,0,1);
      v(1,8'h44, 1,8'h44,3, 0,0,0);
      v(0,8'h00, 0,8'h44,3, 1,0,0);
      v(0,8'h00, 0,8'h44,3, 0,0,0);
      v(1,8'h00, 0,8'h44,3, 0,0,0);
      v(1,8'h7F, 0,8'h44,3, 0,0,0);
      v(1,8'hA5, 0,8'h44,3, 0,0,1);
      v(1,8'h01, 1,8'h01,0, 0,0,1);
      v(1,8'h02, 1,8'h02,1, 0,0,1);
      v(1,8'h03, 1,8'h03,2, 0,0,1);
      v(1,8'h04, 1,8'h04,3, 0,0,0);
      v(0,8'h00, 0,8'h04,3, 1,0,0);
      v(1,8'hA5, 0,8'h04,3, 0,0,1);
      v(1,8'hA5, 1,8'hA5,0, 0,0,1);
      v(1,8'h02, 1,8'h02,1, 0,0,1);
      v(1,8'h03, 1,8'h03,2, 0,0,1);
      v(1,8'h04, 1,8'h04,3, 0,0,0);
      v(1,8'hA5, 0,8'h04,3, 1,0,1);
      v(1,8'h05, 1,8'h05,0, 0,0,1);
      v(1,8'h06, 1,8'h06,1, 0,0,1);
      v(1,8'h07, 1,8'h07,2, 0,0,1);
      v(1,8'h08, 1,8'h08,3, 0,0,0);
      v(0,8'h00, 0,8'h08,3, 1,0,0);
      v(0,8'h00, 0,8'h08,3, 0,0,0);
      foreach (vecs[i]) begin
         cycle(vecs[i].bv, vecs[i].bd);
         check($sformatf("vec%0d update_reg", i), 32'(bus.update_reg), 32'(vecs[i].upd));
         check($sformatf("vec%0d read_data", i),  32'(bus.read_data),  32'(vecs[i].data));
         check($sformatf("vec%0d idx", i),        32'(bus.idx),        32'(vecs[i].idx));
         check($sformatf("vec%0d pc_ready", i),   32'(bus.pc_ready),   32'(vecs[i].pc));
         check($sformatf("vec%0d frame_err", i),  32'(bus.frame_err),  32'(vecs[i].fe));
         check($sformatf("vec%0d busy", i),       32'(bus.busy),       32'(vecs[i].busy));
      end
`endif

      // Inter-byte timeout, then a clean packet
      s_upd = n_upd; s_pc = n_pc; s_fe = n_fe;
      send(8'hA5); send(8'h01); send(8'h02);
      repeat (TO) cycle(1'b0, 8'($urandom));
      check("timeout writes",   32'(n_upd - s_upd), 32'd2);
      check("timeout frame_err",32'(n_fe - s_fe),   32'd1);
      check("timeout pc_ready", 32'(n_pc - s_pc),   32'd0);
      check("timeout busy",     32'(bus.busy),      32'd0);
      s_pc = n_pc; s_fe = n_fe;
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      if (CKS) send(8'h04);
      cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
      check("recovery pc_ready",  32'(n_pc - s_pc), 32'd1);
      check("recovery frame_err", 32'(n_fe - s_fe), 32'd0);

      // Asynchronous reset mid-packet
      send(8'hA5); send(8'h01);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("async rst update_reg", 32'(bus.update_reg), 32'h0);
      check("async rst read_data",  32'(bus.read_data),  32'h0);
      check("async rst busy",       32'(bus.busy),       32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      s_upd = n_upd; s_pc = n_pc; s_fe = n_fe;
      send(8'h02); send(8'h03); send(8'h04); send(8'h05);
      check("post-rst writes",    32'(n_upd - s_upd), 32'd0);
      check("post-rst pc+fe",     32'((n_pc - s_pc) + (n_fe - s_fe)), 32'd0);

`ifdef IA_CHECKSUM_EN
      s_upd = n_upd; s_pc = n_pc; s_fe = n_fe;
      send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
      cycle(1'b0, 8'h00);
      check("cks good pc_ready",  32'(n_pc - s_pc), 32'd1);
      check("cks good frame_err", 32'(n_fe - s_fe), 32'd0);
      s_upd = n_upd; s_pc = n_pc; s_fe = n_fe;
      send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h00);
      cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
      check("cks bad writes",    32'(n_upd - s_upd), 32'd4);
      check("cks bad frame_err", 32'(n_fe - s_fe),   32'd1);
      check("cks bad pc_ready",  32'(n_pc - s_pc),   32'd0);
`endif

      // Randomized stream with occasional long gaps around the timeout
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            gap = $urandom_range(TO - 2, TO + 2);
            repeat (gap) cycle(1'b0, 8'($urandom));
         end else begin
            rbv = ($urandom_range(0, 2) != 0);
            rbd = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
            if (CKS && m_in_pkt && m_got == NB && $urandom_range(0, 1) == 1) rbd = m_xs;
            cycle(rbv, rbd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
